// File: rtl/core_pkg.sv
// Core-wide widths and shared types.
package core_pkg;

  localparam int Xlen = 32;
  localparam int Ilen = 32;

  typedef enum logic {SrcInst, SrcData} mem_src_e;

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO; read data is the registered head, visible while rd_valid_o.
// Latency: one cycle from push to rd_valid_o.
// Backpressure: wr_ready_o low when full; a pop on an empty FIFO is ignored.
module fifo #(
  parameter int DepthLog2 = 2,
  parameter int Width     = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [Width-1:0] wr_data_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [Width-1:0] rd_data_o
);

  localparam int Depth = 1 << DepthLog2;

  logic [Width-1:0]     mem_q [Depth];
  logic [DepthLog2-1:0] wr_ptr_q;
  logic [DepthLog2-1:0] rd_ptr_q;
  logic [DepthLog2:0]   count_q;
  logic                 push;
  logic                 pop;

  // Occupancy never exceeds Depth, so its MSB alone marks full.
  assign wr_ready_o = !count_q[DepthLog2];
  assign rd_valid_o = (count_q != '0);
  assign rd_data_o  = mem_q[rd_ptr_q];

  assign push = wr_valid_i && wr_ready_o;
  assign pop  = rd_ready_i && rd_valid_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction-fetch and data requesters.
// Latency: zero on both request and response paths (purely combinational muxing).
// Backpressure: mem_ready_i passes to the selected requester; reads stall while the tag queue is full.
module mem_arbiter import core_pkg::*; #(
  parameter int Xlen            = core_pkg::Xlen,
  parameter int Ilen            = core_pkg::Ilen,
  parameter int OutstandingLog2 = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              inst_valid_i,
  output logic              inst_ready_o,
  input  logic [Xlen-1:0]   inst_addr_i,
  input  logic [Ilen-1:0]   inst_wdata_i,
  input  logic [Ilen/8-1:0] inst_wmask_i,
  output logic [Ilen-1:0]   inst_rdata_o,
  output logic              inst_rvalid_o,

  input  logic              data_valid_i,
  output logic              data_ready_o,
  input  logic [Xlen-1:0]   data_addr_i,
  input  logic [Ilen-1:0]   data_wdata_i,
  input  logic [Ilen/8-1:0] data_wmask_i,
  output logic [Ilen-1:0]   data_rdata_o,
  output logic              data_rvalid_o,

  input  logic              mem_ready_i,
  output logic              mem_valid_o,
  output logic [Xlen-1:0]   mem_addr_o,
  output logic [Ilen-1:0]   mem_wdata_o,
  output logic [Ilen/8-1:0] mem_wmask_o,
  input  logic [Ilen-1:0]   mem_rdata_i,
  input  logic              mem_rvalid_i,

  output logic              err_o
);

  mem_src_e last_q;
  mem_src_e sel;
  mem_src_e head_src;
  logic     any_valid;
  logic     sel_is_read;
  logic     stall;
  logic     accept;
  logic     tag_push;
  logic     tag_full;
  logic     tag_nonempty;
  logic     tag_wr_ready;
  logic     tag_in;
  logic     tag_out;
  logic     err_q;

  // A tie goes to whoever did not win the last accepted transfer.
  always_comb begin
    sel = SrcData;
    if (inst_valid_i && data_valid_i) begin
      sel = (last_q == SrcInst) ? SrcData : SrcInst;
    end else if (inst_valid_i) begin
      sel = SrcInst;
    end
  end

  always_comb begin
    mem_addr_o  = data_addr_i;
    mem_wdata_o = data_wdata_i;
    mem_wmask_o = data_wmask_i;
    if (sel == SrcInst) begin
      mem_addr_o  = inst_addr_i;
      mem_wdata_o = inst_wdata_i;
      mem_wmask_o = inst_wmask_i;
    end
  end

  assign any_valid   = inst_valid_i || data_valid_i;
  assign sel_is_read = (mem_wmask_o == '0);
  // Fullness is registered occupancy; a same-cycle pop does not free a slot.
  assign stall       = tag_full && sel_is_read;

  assign mem_valid_o  = any_valid && !stall;
  assign inst_ready_o = (sel == SrcInst) && mem_ready_i && !stall;
  assign data_ready_o = (sel == SrcData) && mem_ready_i && !stall;

  assign accept   = mem_valid_o && mem_ready_i;
  assign tag_push = accept && sel_is_read;
  assign tag_in   = sel;
  assign tag_full = !tag_wr_ready;

  fifo #(
    .DepthLog2 (OutstandingLog2),
    .Width     (1)
  ) u_tag_q (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_valid_i (tag_push),
    .wr_ready_o (tag_wr_ready),
    .wr_data_i  (tag_in),
    .rd_valid_o (tag_nonempty),
    .rd_ready_i (mem_rvalid_i),
    .rd_data_o  (tag_out)
  );

  assign head_src = mem_src_e'(tag_out);

  assign inst_rdata_o  = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;
  assign inst_rvalid_o = mem_rvalid_i && tag_nonempty && (head_src == SrcInst);
  assign data_rvalid_o = mem_rvalid_i && tag_nonempty && (head_src == SrcData);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= SrcInst;
      err_q  <= 1'b0;
    end else begin
      if (accept) last_q <= sel;
      // A response with nothing outstanding is dropped and flagged until reset.
      if (mem_rvalid_i && !tag_nonempty) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

endmodule
